// File: rtl/rgb_fade_sequencer_if.sv
// Colour table write bus between a host (master) and the fade sequencer (slave).
// One write per clock: wr_data is {red, green, blue}, each W bits wide.
interface rgb_fade_sequencer_if #(
    parameter int W = 8
);
    logic           wr_en;
    logic [3:0]     wr_addr;
    logic [3*W-1:0] wr_data;

    modport master (
        output wr_en,
        output wr_addr,
        output wr_data
    );

    modport slave (
        input wr_en,
        input wr_addr,
        input wr_data
    );
endinterface

// File: rtl/rgb_fade_sequencer.sv
// Walks a writable colour table, crossfading R/G/B duty words one LSB per step
// tick toward each entry, holding for HOLD_STEPS ticks, then advancing.
module rgb_fade_sequencer #(
    parameter int          PWM_RESOLUTION_BITS = 8,
    parameter int unsigned STEP_DIV            = 32'h0001_0000,
    parameter int          HOLD_STEPS          = 256,
    parameter int          NUM_COLOURS         = 4
) (
    input  logic                           CLK_IP,
    input  logic                           RST_IP,
    input  logic                           enable,
    rgb_fade_sequencer_if.slave            wr,
    output logic [PWM_RESOLUTION_BITS-1:0] red_val,
    output logic [PWM_RESOLUTION_BITS-1:0] green_val,
    output logic [PWM_RESOLUTION_BITS-1:0] blue_val,
    output logic                           pwm_en,
    output logic [3:0]                     colour_idx,
    output logic [1:0]                     state,
    output logic                           step_tick
);

    localparam int          W         = PWM_RESOLUTION_BITS;
    localparam int          HW        = $clog2(HOLD_STEPS + 1);
    localparam logic [31:0] DIV_LAST  = 32'(STEP_DIV - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_STEPS - 1);
    localparam logic [4:0]  NUM_LIMIT = 5'(NUM_COLOURS);
    localparam logic [3:0]  LAST_IDX  = 4'(NUM_COLOURS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FADE = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [W-1:0]   red_q, red_d;
    logic [W-1:0]   green_q, green_d;
    logic [W-1:0]   blue_q, blue_d;
    logic [3:0]     idx_q, idx_d;
    logic [HW-1:0]  hold_q, hold_d;
    logic [31:0]    presc_q, presc_d;
    logic           tick_q, tick_d;
    logic           pwm_en_q;

    // Table is always 16 deep so the 4-bit index never goes out of range;
    // entries at or beyond NUM_COLOURS are never written and stay zero.
    logic [3*W-1:0] table_q [16];

    logic [3*W-1:0] tgt;
    logic [W-1:0]   tgtRed, tgtGreen, tgtBlue;
    logic           tick;

    assign tgt      = table_q[idx_q];
    assign tgtRed   = tgt[3*W-1:2*W];
    assign tgtGreen = tgt[2*W-1:W];
    assign tgtBlue  = tgt[W-1:0];
    assign tick     = (state_q != IDLE) && (presc_q == DIV_LAST);

    function automatic logic [W-1:0] stepToward(input logic [W-1:0] cur, input logic [W-1:0] goal);
        if (cur < goal) begin
            return cur + W'(1);
        end else if (cur > goal) begin
            return cur - W'(1);
        end
        return cur;
    endfunction

    always_ff @(posedge CLK_IP or posedge RST_IP) begin
        if (RST_IP) begin
            for (int i = 0; i < 16; i++) begin
                table_q[i] <= '0;
            end
        end else if (wr.wr_en && ({1'b0, wr.wr_addr} < NUM_LIMIT)) begin
            table_q[wr.wr_addr] <= wr.wr_data;
        end
    end

    always_ff @(posedge CLK_IP or posedge RST_IP) begin
        if (RST_IP) begin
            state_q  <= IDLE;
            red_q    <= '0;
            green_q  <= '0;
            blue_q   <= '0;
            idx_q    <= '0;
            hold_q   <= '0;
            presc_q  <= '0;
            tick_q   <= 1'b0;
            pwm_en_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            red_q    <= red_d;
            green_q  <= green_d;
            blue_q   <= blue_d;
            idx_q    <= idx_d;
            hold_q   <= hold_d;
            presc_q  <= presc_d;
            tick_q   <= tick_d;
            pwm_en_q <= 1'b1;
        end
    end

    // Prescaler runs purely on state; a disable only suppresses the colour update.
    always_comb begin
        state_d = state_q;
        red_d   = red_q;
        green_d = green_q;
        blue_d  = blue_q;
        idx_d   = idx_q;
        hold_d  = hold_q;
        tick_d  = tick;

        if (state_q == IDLE || tick) begin
            presc_d = '0;
        end else begin
            presc_d = presc_q + 32'd1;
        end

        case (state_q)
            IDLE: begin
                if (enable) begin
                    state_d = FADE;
                    idx_d   = '0;
                    hold_d  = '0;
                end
            end
            FADE: begin
                if (!enable) begin
                    state_d = IDLE;
                end else if (tick) begin
                    red_d   = stepToward(red_q, tgtRed);
                    green_d = stepToward(green_q, tgtGreen);
                    blue_d  = stepToward(blue_q, tgtBlue);
                    if ((red_d == tgtRed) && (green_d == tgtGreen) && (blue_d == tgtBlue)) begin
                        state_d = HOLD;
                        hold_d  = '0;
                    end
                end
            end
            HOLD: begin
                if (!enable) begin
                    state_d = IDLE;
                end else if (tick) begin
                    if (hold_q == HOLD_LAST) begin
                        idx_d   = (idx_q == LAST_IDX) ? 4'd0 : idx_q + 4'd1;
                        hold_d  = '0;
                        state_d = FADE;
                    end else begin
                        hold_d = hold_q + HW'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign red_val    = red_q;
    assign green_val  = green_q;
    assign blue_val   = blue_q;
    assign pwm_en     = pwm_en_q;
    assign colour_idx = idx_q;
    assign state      = state_q;
    assign step_tick  = tick_q;

endmodule

// File: tb/tb_rgb_fade_sequencer.sv
// Directed bench for rgb_fade_sequencer with a 4-cycle step tick, 2-tick hold
// and a 2-entry colour table; expected values are worked out by hand.
module tb_rgb_fade_sequencer;

    localparam int W = 8;

    logic         CLK_IP = 1'b0;
    logic         RST_IP = 1'b1;
    logic         enable = 1'b0;
    logic [W-1:0] red_val, green_val, blue_val;
    logic         pwm_en, step_tick;
    logic [3:0]   colour_idx;
    logic [1:0]   state;

    int total = 0;
    int bad   = 0;

    // Expected (red, green, state, colour_idx) after each tick of the
    // entry0={3,0,0}, entry1={0,2,0} sequence starting from black.
    int seqR[12] = '{1, 2, 3, 3, 3, 2, 1, 0, 0, 0, 1, 2};
    int seqG[12] = '{0, 0, 0, 0, 0, 1, 2, 2, 2, 2, 1, 0};
    int seqS[12] = '{1, 1, 2, 2, 1, 1, 1, 2, 2, 1, 1, 1};
    int seqI[12] = '{0, 0, 0, 0, 1, 1, 1, 1, 1, 0, 0, 0};

    rgb_fade_sequencer_if #(.W(W)) wrBus ();

    rgb_fade_sequencer #(
        .PWM_RESOLUTION_BITS(W),
        .STEP_DIV           (4),
        .HOLD_STEPS         (2),
        .NUM_COLOURS        (2)
    ) dut (
        .CLK_IP    (CLK_IP),
        .RST_IP    (RST_IP),
        .enable    (enable),
        .wr        (wrBus.slave),
        .red_val   (red_val),
        .green_val (green_val),
        .blue_val  (blue_val),
        .pwm_en    (pwm_en),
        .colour_idx(colour_idx),
        .state     (state),
        .step_tick (step_tick)
    );

    always #5 CLK_IP = ~CLK_IP;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic checkRgb(input string tag, input int r, input int g, input int b);
        checkOutput({tag, " red"}, 32'(red_val), r);
        checkOutput({tag, " green"}, 32'(green_val), g);
        checkOutput({tag, " blue"}, 32'(blue_val), b);
    endtask

    task automatic checkStatus(input string tag, input int st, input int idx);
        checkOutput({tag, " state"}, 32'(state), st);
        checkOutput({tag, " colour_idx"}, 32'(colour_idx), idx);
    endtask

    task automatic applyStimulus(input logic [3:0] addr, input logic [3*W-1:0] data);
        wrBus.wr_en   = 1'b1;
        wrBus.wr_addr = addr;
        wrBus.wr_data = data;
        @(negedge CLK_IP);
        wrBus.wr_en   = 1'b0;
    endtask

    task automatic waitTick(input string tag, output int waited);
        waited = 0;
        for (int i = 0; i < 16; i++) begin
            @(negedge CLK_IP);
            waited++;
            if (step_tick === 1'b1) break;
        end
        checkOutput({tag, " step_tick"}, 32'(step_tick), 1);
    endtask

    task automatic tickCheck(input string tag, input int r, input int g, input int b,
                             input int st, input int idx, input int period);
        int waited;
        waitTick(tag, waited);
        checkOutput({tag, " period"}, 32'(waited), period);
        checkRgb(tag, r, g, b);
        checkStatus(tag, st, idx);
    endtask

    task automatic runSequence(input string tag);
        for (int i = 0; i < 12; i++) begin
            tickCheck($sformatf("%s t%0d", tag, i + 1), seqR[i], seqG[i], 0, seqS[i], seqI[i], 4);
        end
    endtask

    initial begin
        int seen;
        wrBus.wr_en   = 1'b0;
        wrBus.wr_addr = '0;
        wrBus.wr_data = '0;

        // Power-on reset state
        repeat (2) @(negedge CLK_IP);
        checkRgb("reset", 0, 0, 0);
        checkStatus("reset", 0, 0);
        checkOutput("reset pwm_en", 32'(pwm_en), 0);
        checkOutput("reset step_tick", 32'(step_tick), 0);

        RST_IP = 1'b0;
        @(negedge CLK_IP);
        checkOutput("release pwm_en", 32'(pwm_en), 1);
        repeat (5) @(negedge CLK_IP);
        checkRgb("idle", 0, 0, 0);
        checkStatus("idle", 0, 0);
        checkOutput("idle step_tick", 32'(step_tick), 0);

        // Two-colour sequence: fade, hold, advance, wrap back to entry 0
        applyStimulus(4'd0, {8'd3, 8'd0, 8'd0});
        applyStimulus(4'd1, {8'd0, 8'd2, 8'd0});
        enable = 1'b1;
        @(negedge CLK_IP);
        checkStatus("start", 1, 0);
        runSequence("seq");

        // Freeze mid-fade at red=2, then resume from the frozen value
        enable = 1'b0;
        @(negedge CLK_IP);
        checkStatus("freeze", 0, 0);
        checkRgb("freeze", 2, 0, 0);
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge CLK_IP);
            if (step_tick === 1'b1) seen++;
        end
        checkOutput("freeze ticks", 32'(seen), 0);
        checkRgb("frozen", 2, 0, 0);
        checkStatus("frozen", 0, 0);
        checkOutput("frozen pwm_en", 32'(pwm_en), 1);

        enable = 1'b1;
        @(negedge CLK_IP);
        checkStatus("resume", 1, 0);
        tickCheck("resume t1", 3, 0, 0, 2, 0, 4);

        // Walk to the next fade toward entry 0, then rewrite entry 0 on a tick edge
        tickCheck("w h1", 3, 0, 0, 2, 0, 4);
        tickCheck("w h2", 3, 0, 0, 1, 1, 4);
        tickCheck("w f1", 2, 1, 0, 1, 1, 4);
        tickCheck("w f2", 1, 2, 0, 1, 1, 4);
        tickCheck("w f3", 0, 2, 0, 2, 1, 4);
        tickCheck("w h3", 0, 2, 0, 2, 1, 4);
        tickCheck("w h4", 0, 2, 0, 1, 0, 4);
        tickCheck("w f4", 1, 1, 0, 1, 0, 4);
        repeat (3) @(negedge CLK_IP);
        wrBus.wr_en   = 1'b1;
        wrBus.wr_addr = 4'd0;
        wrBus.wr_data = {8'd0, 8'd0, 8'd5};
        tickCheck("w edge", 2, 0, 0, 1, 0, 1);
        wrBus.wr_en   = 1'b0;
        tickCheck("w n1", 1, 0, 1, 1, 0, 4);
        tickCheck("w n2", 0, 0, 2, 1, 0, 4);
        tickCheck("w n3", 0, 0, 3, 1, 0, 4);
        tickCheck("w n4", 0, 0, 4, 1, 0, 4);
        tickCheck("w n5", 0, 0, 5, 2, 0, 4);

        // Asynchronous reset between clock edges
        @(negedge CLK_IP);
        #2 RST_IP = 1'b1;
        #1;
        checkRgb("async rst", 0, 0, 0);
        checkStatus("async rst", 0, 0);
        checkOutput("async rst pwm_en", 32'(pwm_en), 0);
        checkOutput("async rst step_tick", 32'(step_tick), 0);
        enable = 1'b0;
        @(negedge CLK_IP);
        RST_IP = 1'b0;
        @(negedge CLK_IP);
        checkOutput("rerelease pwm_en", 32'(pwm_en), 1);
        checkStatus("rerelease", 0, 0);

        // Out-of-range writes must leave the table untouched
        applyStimulus(4'd0, {8'd3, 8'd0, 8'd0});
        applyStimulus(4'd1, {8'd0, 8'd2, 8'd0});
        applyStimulus(4'd2, {8'd9, 8'd9, 8'd9});
        applyStimulus(4'd15, {8'd7, 8'd7, 8'd7});
        enable = 1'b1;
        @(negedge CLK_IP);
        checkStatus("oor start", 1, 0);
        runSequence("oor");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rgb_fade_sequencer.md
Name: rgb_fade_sequencer

Overview:
Generates the red/green/blue duty-cycle words and PWM enables that feed the three PWM channel instances in the FPGA top level. It holds a small writable colour table and walks through the entries in order. On each step tick it moves every channel one LSB toward the current target colour (crossfade), holds the target for a programmable number of ticks, then advances to the next entry with wrap-around. It replaces hard-coded duty-cycle case tables with a smooth, reprogrammable sequence.

Parameters:
PWM_RESOLUTION_BITS, 8, width W of each duty-cycle channel.
STEP_DIV, 32'h0001_0000, clock cycles per step tick (>=2).
HOLD_STEPS, 256, step ticks spent holding at each target (>=1).
NUM_COLOURS, 4, colour table depth (1..16).

Ports:
CLK_IP  in  1  fabric clock.
RST_IP  in  1  asynchronous, active-high reset.
enable  in  1  run the sequence; low = freeze outputs.
wr_en  in  1  colour table write strobe.
wr_addr  in  4  table entry index.
wr_data  in  3*W  {red, green, blue} target colour.
red_val  out  W  red duty cycle.
green_val  out  W  green duty cycle.
blue_val  out  W  blue duty cycle.
pwm_en  out  1  enable to all three PWM channels.
colour_idx  out  4  current target entry.
state  out  2  0=IDLE, 1=FADE, 2=HOLD.
step_tick  out  1  one-cycle pulse on each prescaler wrap.

Behaviour:
- Reset (async): all table entries = 0; red/green/blue_val = 0; pwm_en = 0; colour_idx = 0; state = IDLE; prescaler = 0; hold counter = 0; step_tick = 0.
- pwm_en: goes to 1 on the first clock edge after RST_IP deasserts and stays 1 until the next reset.
- All outputs are registered. There is no combinational path from any input to any output.
- Table write:
  - On the edge where wr_en=1 and wr_addr < NUM_COLOURS, the entry is written.
  - wr_addr >= NUM_COLOURS: the write is ignored.
  - Writes are accepted in every state.
  - If a write and a tick land on the same edge, the tick uses the pre-write target. The new target takes effect from the next tick.
- Prescaler:
  - Counts only while state != IDLE.
  - When count == STEP_DIV-1, it wraps to 0 and step_tick=1 for exactly that cycle.
  - It is cleared whenever state is IDLE.
- IDLE:
  - Outputs are frozen.
  - When enable=1, the next edge sets colour_idx=0, clears the hold counter and the prescaler, and moves state to FADE.
- FADE, on each tick, per channel:
  - cur < tgt: cur+1.
  - cur > tgt: cur-1.
  - Equal: unchanged.
  - Channels move independently, with no saturation beyond the target.
  - If all three next values equal their targets on the same edge, state moves to HOLD and the hold counter is set to 0.
  - If the target already equals the current value, HOLD is entered on the first tick.
- HOLD:
  - Outputs are unchanged. The hold counter increments on each tick.
  - On the tick where the hold counter == HOLD_STEPS-1, colour_idx becomes (colour_idx==NUM_COLOURS-1 ? 0 : colour_idx+1) and state moves to FADE.
- enable=0 in FADE or HOLD: the next edge moves state to IDLE. Values are frozen and colour_idx is kept. Re-enabling restarts from entry 0, fading from the frozen values.
- NUM_COLOURS=1: colour_idx stays 0. The block fades once, then re-enters FADE after each hold and immediately returns to HOLD.
- Counter widths: prescaler 32 bit, hold counter $clog2(HOLD_STEPS+1), with no overflow within the parameter ranges.

Test Plan:
1. Bench parameters STEP_DIV=4, HOLD_STEPS=2, NUM_COLOURS=2. Assert RST_IP mid-run → all outputs 0 and state=0 immediately (asynchronous). Release → pwm_en=1 after one edge; values stay 0 while enable=0.
2. Write entry0={3,0,0}, entry1={0,2,0}, then raise enable → step_tick every 4 cycles; red 1,2,3 on ticks 1-3; state=2 on tick 3; held for 2 ticks; then state=1 and colour_idx=1.
3. Continue from scenario 2 → on the next two ticks (red,green) goes (2,1) then (1,2); red reaches 0 on the third tick and state=2. After the hold, colour_idx wraps to 0 and red ramps back to 3.
4. Drop enable mid-fade at red=2 → state=0 on the next edge; values frozen for 20 cycles. Re-enable → colour_idx=0 and the fade continues from red=2.
5. During FADE toward entry0, write entry0={0,0,5} on the tick edge → that tick uses the old target. From the next tick, red decrements and blue increments.
6. Write with wr_addr=2 (>= NUM_COLOURS) → table unchanged; the sequence is identical to scenario 2.
